// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM state type and the transfer-decode helpers
// used by the memory-backed slave responder.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DATA = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } ahb_slv_state_e;

    // Little-endian byte lanes touched by a transfer of the given size/offset.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lo;
            HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    // Sizes above a word and unaligned halfword/word accesses are rejected.
    function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = lo[0];
            HSIZE_WORD: bad = (lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word-organised storage with per-byte synchronous write and combinational read.
// Contents are deliberately not reset.
module ahb_slave_mem_array #(
    parameter int MEM_DEPTH = 1024,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [MEM_DEPTH];

    // Byte-lane write of the enabled lanes only
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave responder backed by a byte-lane word memory, with configurable
// wait states before OKAY completions and two-cycle ERROR responses.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int          MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HPROT,
    input  logic [2:0]  HTRANS,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int         AW      = $clog2(MEM_DEPTH);
    localparam int         OFFW    = AW + 2;
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    ahb_slv_state_e state_r;
    ahb_slv_state_e state_s;
    logic [3:0]     cnt_r;
    logic [3:0]     cnt_s;
    logic           hreadyout_r;
    logic           hresp_r;

    logic [AW-1:0]  idx_r;
    logic [1:0]     lo_r;
    logic           write_r;
    logic [2:0]     size_r;

    logic           in_range_s;
    logic           illegal_s;
    logic           can_accept_s;
    logic           accept_s;
    logic           mem_we_s;
    logic [3:0]     mem_be_s;
    logic [31:0]    mem_rdata_s;
    logic           unused_s;

    // BASE_ADDR is aligned to the window size, so the window test is a compare
    // of the upper address bits and the word index is a plain bit slice.
    assign in_range_s   = (HADDR[31:OFFW] == BASE_ADDR[31:OFFW]);
    assign illegal_s    = xfer_illegal(HSIZE, HADDR[1:0]) || !in_range_s;
    assign can_accept_s = (state_r == IDLE) || (state_r == DATA) || (state_r == ERR2);
    assign accept_s     = can_accept_s && HSEL && HREADY && HTRANS[1];

    // Next-state and wait-counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE, DATA, ERR2: begin
                cnt_s = 4'd0;
                if (accept_s) begin
                    if (illegal_s) begin
                        state_s = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_s = WAIT;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == WS_LAST) begin
                    state_s = DATA;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ERR1: begin
                state_s = ERR2;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State register with handshake outputs decoded from the next state
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            hreadyout_r <= (state_s != WAIT) && (state_s != ERR1);
            hresp_r     <= ((state_s == ERR1) || (state_s == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    // Address-phase capture for the following data phase
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            idx_r   <= '0;
            lo_r    <= 2'd0;
            write_r <= 1'b0;
            size_r  <= 3'd0;
        end else if (accept_s) begin
            idx_r   <= HADDR[OFFW-1:2];
            lo_r    <= HADDR[1:0];
            write_r <= HWRITE;
            size_r  <= HSIZE;
        end
    end

    // Only a legal transfer reaches DATA, so error responses never write.
    assign mem_we_s = (state_r == DATA) && write_r;
    assign mem_be_s = byte_lanes(size_r, lo_r);

    ahb_slave_mem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_array (
        .clk   (HCLK),
        .we    (mem_we_s),
        .be    (mem_be_s),
        .addr  (idx_r),
        .wdata (HWDATA),
        .rdata (mem_rdata_s)
    );

    assign HRDATA    = ((state_r == DATA) && !write_r) ? mem_rdata_s : 32'd0;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

    assign unused_s = ^{HBURST, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench: three slaves with 0, 2 and 3 wait states, each on its own
// single-slave bus where HREADY follows the slave's HREADYOUT.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int ND = 3;

    typedef struct {
        int          dut;
        int          id;
        logic        err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [ND];
    logic        hsel      [ND];
    logic [31:0] haddr     [ND];
    logic        hwrite    [ND];
    logic [2:0]  hsize     [ND];
    logic [2:0]  hburst    [ND];
    logic [2:0]  hprot     [ND];
    logic [2:0]  htrans    [ND];
    logic        hready    [ND];
    logic [31:0] hwdata    [ND];
    logic [31:0] hrdata    [ND];
    logic        hreadyout [ND];
    logic        hresp     [ND];

    exp_t        sbq[$];
    logic [31:0] pend_wd [ND];
    bit          mon_off [ND];
    bit          dp      [ND];
    int          lowcnt  [ND];
    logic        lowresp [ND];
    logic [31:0] lowdata [ND];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          next_id  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        assign hready[g] = hreadyout[g];
        ahb_slave_mem #(
            .MEM_DEPTH   (1024),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .HCLK      (clk),
            .HRST      (rst[g]),
            .HSEL      (hsel[g]),
            .HADDR     (haddr[g]),
            .HWRITE    (hwrite[g]),
            .HSIZE     (hsize[g]),
            .HBURST    (hburst[g]),
            .HPROT     (hprot[g]),
            .HTRANS    (htrans[g]),
            .HREADY    (hready[g]),
            .HWDATA    (hwdata[g]),
            .HRDATA    (hrdata[g]),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Holds the current address phase until the slave is ready at a rising edge.
    task automatic wait_ready(input int d);
        bit rdy = 1'b0;
        for (int i = 0; i < 40 && !rdy; i++) begin
            @(negedge clk);
            rdy = hreadyout[d];
            @(posedge clk);
            #1;
        end
        if (!rdy) begin
            n_fail++;
            $display("FAIL ready_timeout dut%0d: HREADYOUT stayed 0, required 1", d);
        end
    endtask

    task automatic issue(input int d, input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [2:0] sz, input logic [31:0] wd,
                         input logic err, input logic [31:0] rd_exp);
        exp_t e;
        hsel[d]   = sel;
        htrans[d] = {1'b0, tr};
        haddr[d]  = a;
        hwrite[d] = w;
        hsize[d]  = sz;
        hwdata[d] = pend_wd[d];
        if (sel && tr[1]) begin
            e.dut   = d;
            e.id    = next_id;
            e.err   = err;
            e.data  = (err || w) ? 32'd0 : rd_exp;
            e.waits = err ? 1 : ws_of(d);
            next_id++;
            sbq.push_back(e);
        end
        wait_ready(d);
        pend_wd[d] = wd;
    endtask

    task automatic idle(input int d, input int n);
        issue(d, 1'b1, HTRANS_IDLE, 32'd0, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon_step(input int g);
        exp_t e;
        if (rst[g] || mon_off[g]) begin
            dp[g] = 1'b0;
        end else begin
            if (dp[g]) begin
                if (!hreadyout[g]) begin
                    lowcnt[g]++;
                    lowresp[g] = lowresp[g] | hresp[g];
                    lowdata[g] = lowdata[g] | hrdata[g];
                end else begin
                    dp[g] = 1'b0;
                    if (sbq.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_empty dut%0d: completion with no expected transfer", g);
                    end else begin
                        e = sbq.pop_front();
                        chk("hresp", e.id, {31'd0, hresp[g]}, {31'd0, e.err});
                        chk("wait_cycles", e.id, lowcnt[g], e.waits);
                        chk("low_hresp", e.id, {31'd0, lowresp[g]}, {31'd0, e.err});
                        chk("hrdata", e.id, hrdata[g], e.data);
                        chk("low_hrdata", e.id, lowdata[g], 32'd0);
                    end
                end
            end else begin
                chk("idle_ready_resp", g, {30'd0, hreadyout[g], hresp[g]}, 32'd2);
                chk("idle_hrdata", g, hrdata[g], 32'd0);
            end
            if (hsel[g] && hreadyout[g] && htrans[g][1]) begin
                dp[g]      = 1'b1;
                lowcnt[g]  = 0;
                lowresp[g] = 1'b0;
                lowdata[g] = 32'd0;
            end
        end
    endtask

    // Monitor: checks every data phase against the scoreboard
    always @(negedge clk) begin
        for (int g = 0; g < ND; g++) begin
            mon_step(g);
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus
    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d]     = 1'b1;
            hsel[d]    = 1'b0;
            haddr[d]   = 32'd0;
            hwrite[d]  = 1'b0;
            hsize[d]   = HSIZE_WORD;
            hburst[d]  = 3'd0;
            hprot[d]   = 3'd0;
            htrans[d]  = 3'd0;
            hwdata[d]  = 32'd0;
            pend_wd[d] = 32'd0;
            mon_off[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("reset_hreadyout", d, {31'd0, hreadyout[d]}, 32'd1);
            chk("reset_hresp", d, {31'd0, hresp[d]}, 32'd0);
            chk("reset_hrdata", d, hrdata[d], 32'd0);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        @(posedge clk);
        #1;

        // Word write then pipelined read of the same word; also seed word 0
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0, 32'd0);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'hDEAD_BEEF);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h00, 1'b1, HSIZE_WORD, 32'h0BAD_C0DE, 1'b0, 32'd0);
        idle(0, 2);

        // Byte and halfword writes merge into the stored word
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h13, 1'b1, HSIZE_BYTE, 32'hAA11_2233, 1'b0, 32'd0);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_HALF, 32'h7777_5566, 1'b0, 32'd0);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'hAAAD_5566);
        idle(0, 2);

        // Error responses: misaligned, out of range, oversized; none may write
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h02, 1'b0, HSIZE_WORD, 32'd0, 1'b1, 32'd0);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h1000, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, 1'b1, 32'd0);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h12, 1'b1, HSIZE_WORD, 32'h1234_5678, 1'b1, 32'd0);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h11, 1'b1, HSIZE_HALF, 32'h9999_9999, 1'b1, 32'd0);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, 3'd3, 32'd0, 1'b1, 32'd0);
        issue(0, 1'b0, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'h5555_5555, 1'b0, 32'd0);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h00, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'h0BAD_C0DE);
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'hAAAD_5566);
        idle(0, 2);

        // INCR4 burst writes, then burst reads with a BUSY after beat 2
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h40, 1'b1, HSIZE_WORD, 32'hB000_0040, 1'b0, 32'd0);
        issue(0, 1'b1, HTRANS_SEQ,    32'h44, 1'b1, HSIZE_WORD, 32'hB000_0044, 1'b0, 32'd0);
        issue(0, 1'b1, HTRANS_SEQ,    32'h48, 1'b1, HSIZE_WORD, 32'hB000_0048, 1'b0, 32'd0);
        issue(0, 1'b1, HTRANS_SEQ,    32'h4C, 1'b1, HSIZE_WORD, 32'hB000_004C, 1'b0, 32'd0);
        idle(0, 1);
        hburst[0] = 3'b011;
        hprot[0]  = 3'b101;
        issue(0, 1'b1, HTRANS_NONSEQ, 32'h40, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'hB000_0040);
        issue(0, 1'b1, HTRANS_SEQ,    32'h44, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'hB000_0044);
        issue(0, 1'b1, HTRANS_BUSY,   32'h48, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'd0);
        issue(0, 1'b1, HTRANS_SEQ,    32'h48, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'hB000_0048);
        issue(0, 1'b1, HTRANS_SEQ,    32'h4C, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'hB000_004C);
        hburst[0] = 3'd0;
        hprot[0]  = 3'd0;
        idle(0, 2);

        // Two wait states per beat; the held next address goes in only on the ready edge
        issue(1, 1'b1, HTRANS_NONSEQ, 32'h20, 1'b1, HSIZE_WORD, 32'h1111_2222, 1'b0, 32'd0);
        issue(1, 1'b1, HTRANS_NONSEQ, 32'h24, 1'b1, HSIZE_WORD, 32'h3333_4444, 1'b0, 32'd0);
        issue(1, 1'b1, HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'h1111_2222);
        issue(1, 1'b1, HTRANS_SEQ,    32'h24, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'h3333_4444);
        issue(1, 1'b1, HTRANS_NONSEQ, 32'h21, 1'b0, HSIZE_HALF, 32'd0, 1'b1, 32'd0);
        idle(1, 2);

        // Reset in the middle of a write's wait states drops the write
        issue(2, 1'b1, HTRANS_NONSEQ, 32'h30, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 1'b0, 32'd0);
        idle(2, 2);
        mon_off[2] = 1'b1;
        hsel[2]    = 1'b1;
        htrans[2]  = {1'b0, HTRANS_NONSEQ};
        haddr[2]   = 32'h30;
        hwrite[2]  = 1'b1;
        hsize[2]   = HSIZE_WORD;
        hwdata[2]  = pend_wd[2];
        wait_ready(2);
        htrans[2]  = {1'b0, HTRANS_IDLE};
        hwdata[2]  = 32'h1234_5678;
        @(negedge clk);
        chk("mid_wait_hreadyout", 2, {31'd0, hreadyout[2]}, 32'd0);
        #2;
        rst[2] = 1'b1;
        #1;
        chk("async_rst_hreadyout", 2, {31'd0, hreadyout[2]}, 32'd1);
        chk("async_rst_hresp", 2, {31'd0, hresp[2]}, 32'd0);
        chk("async_rst_hrdata", 2, hrdata[2], 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst[2]     = 1'b0;
        pend_wd[2] = 32'd0;
        @(posedge clk);
        #1;
        mon_off[2] = 1'b0;
        issue(2, 1'b1, HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD, 32'd0, 1'b0, 32'hCAFE_F00D);
        idle(2, 3);

        chk("sb_drain", 0, sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
